// File: rtl/parking_gate_actuator.sv
// Parking gate actuator: five-state gate FSM driving the raise/lower motors,
// with travel timing, vehicle pass detection, auto-close and reverse-on-obstacle.
module parking_gate_actuator #(
    parameter int TRAVEL_CYCLES     = 8,
    parameter int AUTO_CLOSE_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       open_gate,
    input  logic       close_gate,
    input  logic       blocked_gate,
    input  logic       vehicle_sensor,
    output logic       gate_ack,
    output logic       vehicle_left,
    output logic       motor_up,
    output logic       motor_down,
    output logic [2:0] gate_state
);

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_LOCKED  = 3'd4
    } state_t;

    localparam logic [7:0] TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] IDLE_LOAD   = 8'(AUTO_CLOSE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] travel_cnt_q, travel_cnt_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic       seen_q, seen_d;
    logic       sensor_prev_q, sensor_prev_d;
    logic       gate_ack_q, gate_ack_d;
    logic       vehicle_left_q, vehicle_left_d;

    // Decrement that stops at zero so a counter can never wrap.
    function automatic logic [7:0] sat_dec(input logic [7:0] x);
        return (x == 8'd0) ? 8'd0 : x - 8'd1;
    endfunction

    // Travel needed to retrace the distance already covered by an aborted close.
    function automatic logic [7:0] reverse_cnt(input logic [7:0] t);
        return (t > TRAVEL_LOAD) ? 8'd0 : TRAVEL_LOAD - t;
    endfunction

    // Next-state, counter and pulse computation.
    always_comb begin
        state_d        = state_q;
        travel_cnt_d   = travel_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        seen_d         = seen_q;
        sensor_prev_d  = vehicle_sensor;
        gate_ack_d     = 1'b0;
        vehicle_left_d = 1'b0;
        case (state_q)
            ST_CLOSED: begin
                if (blocked_gate) begin
                    state_d = ST_LOCKED;
                end else if (open_gate) begin
                    state_d      = ST_OPENING;
                    travel_cnt_d = TRAVEL_LOAD;
                end
            end
            ST_LOCKED: begin
                if (!blocked_gate) state_d = ST_CLOSED;
            end
            ST_OPENING: begin
                if (travel_cnt_q == 8'd0) begin
                    state_d    = ST_OPEN;
                    gate_ack_d = 1'b1;
                    seen_d     = 1'b0;
                    idle_cnt_d = IDLE_LOAD;
                end else begin
                    travel_cnt_d = sat_dec(travel_cnt_q);
                end
            end
            ST_OPEN: begin
                // A vehicle has fully passed once the sensor falls after being seen.
                if (sensor_prev_q && !vehicle_sensor && seen_q) begin
                    vehicle_left_d = 1'b1;
                    seen_d         = 1'b0;
                end
                if (vehicle_sensor) begin
                    seen_d     = 1'b1;
                    idle_cnt_d = IDLE_LOAD;
                end else if (close_gate) begin
                    state_d      = ST_CLOSING;
                    travel_cnt_d = TRAVEL_LOAD;
                end else if (idle_cnt_q == 8'd0) begin
                    state_d      = ST_CLOSING;
                    travel_cnt_d = TRAVEL_LOAD;
                end else begin
                    idle_cnt_d = sat_dec(idle_cnt_q);
                end
            end
            ST_CLOSING: begin
                // Obstacle or new open request wins over completing the close.
                if (vehicle_sensor || open_gate) begin
                    state_d      = ST_OPENING;
                    travel_cnt_d = reverse_cnt(travel_cnt_q);
                end else if (travel_cnt_q == 8'd0) begin
                    state_d    = ST_CLOSED;
                    gate_ack_d = 1'b1;
                end else begin
                    travel_cnt_d = sat_dec(travel_cnt_q);
                end
            end
            default: begin
                state_d = ST_CLOSED;
            end
        endcase
    end

    // State and counter registers; reset forces the gate closed and idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_CLOSED;
            travel_cnt_q   <= 8'd0;
            idle_cnt_q     <= 8'd0;
            seen_q         <= 1'b0;
            sensor_prev_q  <= 1'b0;
            gate_ack_q     <= 1'b0;
            vehicle_left_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            travel_cnt_q   <= travel_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            seen_q         <= seen_d;
            sensor_prev_q  <= sensor_prev_d;
            gate_ack_q     <= gate_ack_d;
            vehicle_left_q <= vehicle_left_d;
        end
    end

    // Motors decode straight from the state register so reset stops them at once.
    assign motor_up     = (state_q == ST_OPENING);
    assign motor_down   = (state_q == ST_CLOSING);
    assign gate_state   = state_q;
    assign gate_ack     = gate_ack_q;
    assign vehicle_left = vehicle_left_q;

endmodule
